// File: rtl/store_check_responder_if.sv
// Bundle of the CPU data-write port, status readback and store-log pop port seen by store_check_responder.
interface store_check_responder_if;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        log_rd_en;
  logic        log_rd_valid;
  logic [31:0] log_rd_addr;
  logic [31:0] log_rd_data;
  logic        log_empty;
  logic        log_full;
  logic        pass;
  logic        fail;
  logic [15:0] store_count;

  modport master (
    output memwrite, aluout, writedata, log_rd_en,
    input  readdata, log_rd_valid, log_rd_addr, log_rd_data,
    input  log_empty, log_full, pass, fail, store_count
  );

  modport slave (
    input  memwrite, aluout, writedata, log_rd_en,
    output readdata, log_rd_valid, log_rd_addr, log_rd_data,
    output log_empty, log_full, pass, fail, store_count
  );
endinterface

// File: rtl/store_check_responder.sv
// Store logger and end-of-program checker beside dmem; status word readable at STATUS_ADDR.
// Optional watchdog enabled by defining STORE_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | out of reset, no store seen yet
// RUN    | at least one store logged, waiting for check store
// PASS   | check store matched CHECK_DATA (terminal)
// FAIL   | check store mismatched or watchdog expired (terminal)
module store_check_responder #(
  parameter logic [31:0] CHECK_ADDR     = 32'd36,
  parameter logic [31:0] CHECK_DATA     = 32'hFFFF_FFFA,
  parameter logic [31:0] STATUS_ADDR    = 32'h0000_0100,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input logic                    clk,
  input logic                    reset,
  store_check_responder_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  if ((FIFO_DEPTH < 2) || ((1 << AW) != FIFO_DEPTH)) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t          state, state_nxt;
  logic            active, accept, check_hit, check_ok, timeout_hit;
  logic            push, pop, empty, full;
  logic [AW:0]     occ;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     mem_addr [FIFO_DEPTH];
  logic [31:0]     mem_data [FIFO_DEPTH];
  logic            overflow, timeout_flag;
  logic [15:0]     cnt;

  assign active    = (state == S_IDLE) || (state == S_RUN);
  assign accept    = active && bus.memwrite;
  assign check_hit = accept && (bus.aluout == CHECK_ADDR);
  assign check_ok  = (bus.writedata == CHECK_DATA);

  assign empty = (occ == '0);
  assign full  = (occ == DEPTH_C);
  assign pop   = bus.log_rd_en && !empty;
  assign push  = accept && (!full || pop);

`ifdef STORE_TIMEOUT_EN
  logic [31:0] tmr;

  // Down-counter loaded at reset; terminal count while active trips the watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr          <= 32'(TIMEOUT_CYCLES - 1);
      timeout_flag <= 1'b0;
    end else if (active) begin
      if (tmr != '0)
        tmr <= tmr - 32'd1;
      else if (!check_hit)
        timeout_flag <= 1'b1;
    end
  end

  assign timeout_hit = active && (tmr == '0);
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // A check store on the same edge as watchdog expiry takes precedence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN: begin
        if (check_hit)        state_nxt = check_ok ? S_PASS : S_FAIL;
        else if (timeout_hit) state_nxt = S_FAIL;
        else if (accept)      state_nxt = S_RUN;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= bus.aluout;
      mem_data[wr_ptr] <= bus.writedata;
    end
  end

  // When full with a pop, wr_ptr==rd_ptr: the read below still sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      overflow         <= 1'b0;
      bus.log_rd_valid <= 1'b0;
      bus.log_rd_addr  <= '0;
      bus.log_rd_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (accept && !push) overflow <= 1'b1;
      bus.log_rd_valid <= pop;
      if (pop) begin
        bus.log_rd_addr <= mem_addr[rd_ptr];
        bus.log_rd_data <= mem_data[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (accept && (cnt != 16'hFFFF))
      cnt <= cnt + 16'd1;
  end

  assign bus.pass        = (state == S_PASS);
  assign bus.fail        = (state == S_FAIL);
  assign bus.log_empty   = empty;
  assign bus.log_full    = full;
  assign bus.store_count = cnt;
  assign bus.readdata    = (bus.aluout == STATUS_ADDR)
                         ? {bus.pass, bus.fail, overflow, timeout_flag, 12'b0, cnt}
                         : 32'd0;

endmodule

// File: tb/tb_store_check_responder.sv
// Bench for store_check_responder: vector table, corner sequences and random traffic vs. a queue model.
module tb_store_check_responder;

  localparam logic [31:0] CHECK_ADDR  = 32'd36;
  localparam logic [31:0] CHECK_DATA  = 32'hFFFF_FFFA;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_0100;
  localparam int          DEPTH       = 8;
  localparam int          TMO         = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_check_responder_if bus();

  store_check_responder #(
    .CHECK_ADDR(CHECK_ADDR), .CHECK_DATA(CHECK_DATA), .STATUS_ADDR(STATUS_ADDR),
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: verdict 0=none 1=pass 2=fail
  int          m_verdict;
  logic [63:0] mq[$];
  int          m_cnt;
  bit          m_ovf, m_tmo;
  int          m_edges;
  bit          e_valid;
  logic [31:0] e_raddr, e_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_verdict = 0; mq.delete(); m_cnt = 0; m_ovf = 0; m_tmo = 0; m_edges = 0;
    e_valid = 0; e_raddr = 0; e_rdata = 0;
  endfunction

  function automatic void model_edge(bit mw, logic [31:0] addr, logic [31:0] data, bit rd);
    logic [63:0] ent;
    bit act, acc;
    act = (m_verdict == 0);
    acc = mw && act;
    e_valid = 0;
    if (rd && mq.size() > 0) begin
      ent = mq.pop_front();
      e_valid = 1; e_raddr = ent[63:32]; e_rdata = ent[31:0];
    end
    if (acc) begin
      if (m_cnt < 65535) m_cnt++;
      if (mq.size() < DEPTH) mq.push_back({addr, data});
      else m_ovf = 1;
    end
    if (act) begin
      if (acc && addr == CHECK_ADDR) m_verdict = (data == CHECK_DATA) ? 1 : 2;
`ifdef STORE_TIMEOUT_EN
      else if (m_edges == TMO - 1) begin m_verdict = 2; m_tmo = 1; end
      else m_edges++;
`endif
    end
  endfunction

  function automatic logic [31:0] model_status(logic [31:0] addr);
    if (addr != STATUS_ADDR) return 32'd0;
    return {m_verdict == 1, m_verdict == 2, m_ovf, m_tmo, 12'b0, 16'(m_cnt)};
  endfunction

  task automatic compare_all();
    chk("pass", bus.pass, m_verdict == 1);
    chk("fail", bus.fail, m_verdict == 2);
    chk("log_empty", bus.log_empty, mq.size() == 0);
    chk("log_full", bus.log_full, mq.size() == DEPTH);
    chk("store_count", bus.store_count, m_cnt);
    chk("log_rd_valid", bus.log_rd_valid, e_valid);
    if (e_valid) begin
      chk("log_rd_addr", bus.log_rd_addr, e_raddr);
      chk("log_rd_data", bus.log_rd_data, e_rdata);
    end
    chk("readdata", bus.readdata, model_status(bus.aluout));
  endtask

  task automatic step(input bit mw, input logic [31:0] addr, input logic [31:0] data, input bit rd);
    bus.memwrite = mw; bus.aluout = addr; bus.writedata = data; bus.log_rd_en = rd;
    model_edge(mw, addr, data, rd);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    bus.memwrite = 0; bus.aluout = 0; bus.writedata = 0; bus.log_rd_en = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    chk("rst_pass", bus.pass, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_empty", bus.log_empty, 1);
    chk("rst_full", bus.log_full, 0);
    chk("rst_count", bus.store_count, 0);
    chk("rst_valid", bus.log_rd_valid, 0);
  endtask

  typedef struct {
    bit          mw;
    logic [31:0] addr;
    logic [31:0] data;
    bit          rd;
    bit          e_pass;
    bit          e_fail;
    int          e_cnt;
    bit          e_empty;
    bit          e_valid;
    logic [31:0] e_raddr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] a, d;
    int sel;

    vecs[0] = '{1, 32'd40, 32'd7,      0, 0, 0, 1, 0, 0, 0, 0};
    vecs[1] = '{1, 32'd44, 32'd9,      0, 0, 0, 2, 0, 0, 0, 0};
    vecs[2] = '{1, 32'd36, CHECK_DATA, 0, 1, 0, 3, 0, 0, 0, 0};
    vecs[3] = '{1, 32'd36, 32'd5,      0, 1, 0, 3, 0, 0, 0, 0};
    vecs[4] = '{0, 32'd0,  32'd0,      1, 1, 0, 3, 0, 1, 32'd40, 32'd7};
    vecs[5] = '{0, 32'd0,  32'd0,      1, 1, 0, 3, 0, 1, 32'd44, 32'd9};
    vecs[6] = '{0, 32'd0,  32'd0,      1, 1, 0, 3, 1, 1, 32'd36, CHECK_DATA};
    vecs[7] = '{0, 32'd0,  32'd0,      1, 1, 0, 3, 1, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].mw, vecs[i].addr, vecs[i].data, vecs[i].rd);
      chk($sformatf("vec%0d_pass", i), bus.pass, vecs[i].e_pass);
      chk($sformatf("vec%0d_fail", i), bus.fail, vecs[i].e_fail);
      chk($sformatf("vec%0d_cnt", i), bus.store_count, vecs[i].e_cnt);
      chk($sformatf("vec%0d_empty", i), bus.log_empty, vecs[i].e_empty);
      chk($sformatf("vec%0d_valid", i), bus.log_rd_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_raddr", i), bus.log_rd_addr, vecs[i].e_raddr);
        chk($sformatf("vec%0d_rdata", i), bus.log_rd_data, vecs[i].e_rdata);
      end
    end

    // Mismatching check store, then a matching one that must be ignored
    do_reset();
    step(1, 32'd36, 32'd5, 0);
    chk("mis_fail", bus.fail, 1);
    chk("mis_pass", bus.pass, 0);
    step(1, 32'd36, CHECK_DATA, 0);
    chk("mis_late_cnt", bus.store_count, 1);
    chk("mis_late_pass", bus.pass, 0);
    step(0, STATUS_ADDR, 0, 0);
    chk("mis_status", bus.readdata, 32'h4000_0001);

    // Nine stores without pops: ninth is dropped
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 32'h200 + 32'(4*i), 32'(100 + i), 0);
    chk("ovf_full", bus.log_full, 1);
    step(0, STATUS_ADDR, 0, 0);
    chk("ovf_status", bus.readdata, 32'h2000_0009);
    step(0, 32'h104, 0, 0);
    chk("other_addr_rd", bus.readdata, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1);
      chk($sformatf("ovf_pop%0d_addr", i), bus.log_rd_addr, 32'h200 + 32'(4*i));
      chk($sformatf("ovf_pop%0d_data", i), bus.log_rd_data, 32'(100 + i));
    end
    step(0, 0, 0, 1);
    chk("ovf_pop_empty_valid", bus.log_rd_valid, 0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 32'h200 + 32'(4*i), 32'(i), 0);
    step(1, 32'h300, 32'd55, 1);
    chk("fp_full", bus.log_full, 1);
    chk("fp_valid", bus.log_rd_valid, 1);
    chk("fp_first", bus.log_rd_addr, 32'h200);
    step(0, STATUS_ADDR, 0, 0);
    chk("fp_status", bus.readdata, 32'h0000_0009);
    for (int i = 1; i < 9; i++) begin
      step(0, 0, 0, 1);
      chk($sformatf("fp_pop%0d", i), bus.log_rd_addr, (i < 8) ? 32'h200 + 32'(4*i) : 32'h300);
    end

`ifdef STORE_TIMEOUT_EN
    do_reset();
    for (int i = 0; i < TMO - 1; i++) step(0, 0, 0, 0);
    chk("tmo_not_yet", bus.fail, 0);
    step(0, STATUS_ADDR, 0, 0);
    chk("tmo_fail", bus.fail, 1);
    chk("tmo_status", bus.readdata, 32'h5000_0000);
`endif

    // Random traffic, including a reset mid-operation
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        if (i == 150) do_reset();
        sel = int'($urandom_range(0, 19));
        if (sel == 0) a = CHECK_ADDR;
        else if (sel < 3) a = STATUS_ADDR;
        else a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        d = ($urandom_range(0, 1) == 1) ? CHECK_DATA : $urandom;
        step($urandom_range(0, 1) == 1, a, d, $urandom_range(0, 9) < 4);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
